// File: rtl/input_controller.sv
// DE2 pushbutton/switch front end for the card game.
// Produces single-shot, prioritised commands behind a valid/ready buffer.
module input_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BET_W           = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       key_n,
    input  logic [BET_W-1:0] sw,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [1:0]       cmd,
    output logic [BET_W-1:0] cmd_bet,
    output logic [3:0]       key_level,
    output logic [7:0]       drop_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    logic [3:0]       r_key_s1;
    logic [3:0]       r_key_s2;
    logic [BET_W-1:0] r_sw_s1;
    logic [BET_W-1:0] r_sw_s2;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_level;
    state_t           r_state;
    logic [1:0]       r_cmd;
    logic [BET_W-1:0] r_bet;
    logic [7:0]       r_drop;

    logic [3:0]       w_pressed;
    logic [3:0]       w_event;
    logic [2:0]       w_n_ev;
    logic [1:0]       w_top;
    state_t           w_next;
    logic             w_load;
    logic [2:0]       w_drop_n;
    logic [8:0]       w_drop_sum;

    assign w_pressed = ~r_key_s2;

    // Two-flop synchronizers; keys idle high (released) out of reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= key_n;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Per-key debounce: level flips after DEBOUNCE_CYCLES differing samples
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
            r_level <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_pressed[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_cnt[i]   <= '0;
                    r_level[i] <= ~r_level[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press events fire in the cycle before key_level rises, so the
    // command lands on the same edge as the level
    always_comb begin
        w_event = '0;
        for (int i = 0; i < 4; i++) begin
            w_event[i] = w_pressed[i] & ~r_level[i] & (r_cnt[i] == CNT_LAST);
        end
    end

    assign w_n_ev = 3'(w_event[0]) + 3'(w_event[1])
                  + 3'(w_event[2]) + 3'(w_event[3]);

    // Priority encode: new game > deal > stand > hit
    always_comb begin
        w_top = 2'd0;
        if (w_event[3])      w_top = 2'd3;
        else if (w_event[2]) w_top = 2'd2;
        else if (w_event[1]) w_top = 2'd1;
    end

    // Next state, load strobe and number of events discarded this cycle
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_n_ev != 3'd0) begin
                    w_load = 1'b1;
                    w_next = PEND;
                end
            end
            PEND: begin
                if (cmd_ready) begin
                    if (w_n_ev != 3'd0) w_load = 1'b1;
                    else                w_next = IDLE;
                end
            end
        endcase
        w_drop_n = w_load ? (w_n_ev - 3'd1) : w_n_ev;
    end

    assign w_drop_sum = {1'b0, r_drop} + 9'(w_drop_n);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Command buffer contents, captured with the synchronized bet
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cmd <= '0;
            r_bet <= '0;
        end else if (w_load) begin
            r_cmd <= w_top;
            r_bet <= r_sw_s2;
        end
    end

    // Saturating dropped-press counter
    always_ff @(posedge clk) begin
        if (!reset_n)          r_drop <= '0;
        else if (w_drop_sum[8]) r_drop <= 8'hFF;
        else                   r_drop <= w_drop_sum[7:0];
    end

    assign cmd_valid  = (r_state == PEND);
    assign cmd        = r_cmd;
    assign cmd_bet    = r_bet;
    assign key_level  = r_level;
    assign drop_count = r_drop;

endmodule

// File: doc/input_controller.md
Name: input_controller

Overview:
- Input-side counterpart of the game's display/output path. Converts raw DE2 pushbuttons and switches into clean, single-shot game commands (hit, stand, deal, new game) for the game FSM.
- Per-key processing: 2-flop synchronizer, then debounce, then press-edge detect, then priority encode.
- One command is held in a single-entry valid/ready buffer until the game FSM accepts it.
- Also exports debounced key levels for LED feedback and a saturating count of dropped presses.

Parameters:
- DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); legal range is 1 or more.
- BET_W, default 8, width of the bet switch field and cmd_bet.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- key_n  input  4  raw pushbuttons, active-low; [0]=hit, [1]=stand, [2]=deal, [3]=new game
- sw  input  BET_W  raw bet switches, asynchronous
- cmd_ready  input  1  game FSM accepts the current command this cycle
- cmd_valid  output  1  a command is pending
- cmd  output  2  command code: 00=hit, 01=stand, 10=deal, 11=new game
- cmd_bet  output  BET_W  bet captured with the command; meaningful when cmd=10
- key_level  output  4  debounced pressed state, 1 = pressed
- drop_count  output  8  saturating count of discarded press events

Behaviour:
- Reset, on a clk edge with reset_n=0:
  - cmd_valid=0, cmd=0, cmd_bet=0, key_level=0, drop_count=0.
  - Synchronizer flops load 1 (released). Debounce counters load 0. State goes to IDLE.
  - Any in-progress debounce or pending command is discarded.
- Synchronizer: key_n goes through 2 flops per bit; sw goes through 2 flops per bit.
- Debounce, per key:
  - Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
  - If the synchronized pressed value equals key_level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, key_level toggles and the counter clears on the same edge.
- Press event: a one-cycle internal pulse when key_level goes 0 to 1. A release generates no event.
- Latency:
  - key_level rises on edge t+DEBOUNCE_CYCLES+1, where t is the first edge sampling key_n low that is followed by a continuous low.
  - cmd_valid rises on the same edge as key_level.
- Priority when several press events occur in one cycle: new game > deal > stand > hit. Only the highest is captured; every other event counts as a drop.
- State machine:
  - IDLE: on any press event, load cmd, load cmd_bet from the synchronized sw, set cmd_valid=1, go to PEND.
  - PEND: cmd, cmd_bet and cmd_valid are held stable. sw changes have no effect.
    - On a cycle with cmd_ready=1: if a press event also occurs that cycle, load the new command, keep cmd_valid=1 and stay in PEND (back-to-back transfer). Otherwise cmd_valid=0 next edge and go to IDLE.
    - On a cycle with cmd_ready=0: all press events that cycle are dropped.
- cmd_bet is loaded for every command. Consumers use it only for deal.
- drop_count:
  - Adds the number of dropped events each cycle (0 to 4).
  - Saturates at 255 and never wraps.
  - Cleared only by reset.
- cmd_ready while cmd_valid=0 is ignored.

Test Plan (DEBOUNCE_CYCLES=4, BET_W=8):
- Clean hit: key_n[0] held low 12 cycles, cmd_ready=1.
  - cmd_valid high exactly 1 cycle, cmd=00, rising 5 edges after first low sample.
  - key_level[0]=1 until 5 edges after release. No second command.
- Bounce: key_n[1] toggles every 2 cycles for 16 cycles, then held low.
  - No command during the bounce.
  - Exactly one cmd=01 after 5 continuous low edges. drop_count=0.
- Back-pressure: sw=25, press key2, cmd_ready=0 for 6 cycles, sw changes to 50 mid-wait.
  - cmd_valid held, cmd=10, cmd_bet=25 throughout.
  - cmd_valid drops the edge after cmd_ready=1.
- Drop while pending: with deal pending and cmd_ready=0, press hit.
  - drop_count=1.
  - After deal is accepted, cmd_valid=0 and no hit command appears.
- Simultaneous presses: key3 and key0 debounce on the same cycle.
  - Single cmd=11, drop_count increments by 1.
  - Separately, 300 dropped events leave drop_count=255.
- Reset mid-operation: reset_n=0 for 1 cycle while a command is pending and key2 is held.
  - Next edge: cmd_valid=0, drop_count=0, key_level=0.
  - After release of reset with key2 still held, cmd=10 is issued 5 edges later.
